// File: rtl/conv1d_psum_accum_pkg.sv
// rtl/conv1d_psum_accum_pkg.sv - shared widths and sizing helpers for the conv1d partial-sum accumulator
package conv1d_psum_accum_pkg;

    // Datapath width shared with the MAC chain; partial sums and bias are twice this wide.
    localparam int WIDTH_DATA  = 8;
    localparam int PSUM_W      = 2 * WIDTH_DATA;
    localparam int ACC_LEN_DEF = 27;
    localparam int SHIFT_W_DEF = 5;

    // Accumulator width that cannot overflow for acc_len beats plus one bias term.
    function automatic int acc_width(input int acc_len);
        return PSUM_W + $clog2(acc_len) + 2;
    endfunction

endpackage

// File: rtl/conv1d_psum_accum_if.sv
// rtl/conv1d_psum_accum_if.sv - valid/ready input and output bundle of the partial-sum accumulator
//   in_valid/in_ready/in_psum/in_bias/cfg_shift : partial-sum beat from the MAC chain
//   out_valid/out_ready/out_data/out_ovf        : requantised result towards writeback
//   slv modport: accumulator side; mst modport: producer/consumer side
interface conv1d_psum_accum_if #(
    parameter int WIDTH_DATA = 8,
    parameter int SHIFT_W    = 5
);
    logic                           in_valid;
    logic                           in_ready;
    logic signed [2*WIDTH_DATA-1:0] in_psum;
    logic signed [2*WIDTH_DATA-1:0] in_bias;
    logic        [SHIFT_W-1:0]      cfg_shift;
    logic                           out_valid;
    logic                           out_ready;
    logic signed [WIDTH_DATA-1:0]   out_data;
    logic                           out_ovf;

    modport slv (
        input  in_valid, in_psum, in_bias, cfg_shift, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );

    modport mst (
        output in_valid, in_psum, in_bias, cfg_shift, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/conv1d_round_sat.sv
// rtl/conv1d_round_sat.sv - round-half-up arithmetic right shift, optional ReLU, saturation
//   acc   : signed accumulator value
//   shift : right-shift amount (any value, including >= ACC_W)
//   data  : saturated WIDTH_DATA result
//   ovf   : result was clamped
//   Optional feature macro: CONV1D_ACC_RELU_EN (negative results forced to 0 before saturation)
module conv1d_round_sat #(
    parameter int ACC_W      = 22,
    parameter int SHIFT_W    = 5,
    parameter int WIDTH_DATA = 8
) (
    input  logic signed [ACC_W-1:0]      acc,
    input  logic        [SHIFT_W-1:0]    shift,
    output logic signed [WIDTH_DATA-1:0] data,
    output logic                         ovf
);
    // Wide enough to hold the rounding constant for the largest shift without wrapping,
    // so large shifts collapse cleanly to 0 or -1.
    localparam int SPAN  = 1 << SHIFT_W;
    localparam int EXT_W = ((ACC_W > SPAN) ? ACC_W : SPAN) + 2;
    localparam logic signed [EXT_W-1:0] MAX_V = EXT_W'((longint'(1) << (WIDTH_DATA - 1)) - 1);
    localparam logic signed [EXT_W-1:0] MIN_V = -MAX_V - EXT_W'(1);

    logic signed [EXT_W-1:0] acc_ext;
    logic signed [EXT_W-1:0] half;
    logic signed [EXT_W-1:0] sum;
    logic signed [EXT_W-1:0] r;
    logic signed [EXT_W-1:0] r_sat;

    always_comb begin
        acc_ext = EXT_W'(acc);
        half    = '0;
        if (shift != '0) begin
            half = EXT_W'(1) << (shift - SHIFT_W'(1));
        end
        sum = acc_ext + half;
        r   = sum >>> shift;
`ifdef CONV1D_ACC_RELU_EN
        if (r < 0) begin
            r = '0;
        end
`endif
        ovf   = 1'b0;
        r_sat = r;
        if (r > MAX_V) begin
            r_sat = MAX_V;
            ovf   = 1'b1;
        end else if (r < MIN_V) begin
            r_sat = MIN_V;
            ovf   = 1'b1;
        end
        data = WIDTH_DATA'(r_sat);
    end
endmodule

// File: rtl/conv1d_psum_accum.sv
// rtl/conv1d_psum_accum.sv - accumulates ACC_LEN partial sums on a bias, then requantises
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   clr   : synchronous abort, drops partial sums and any pending result
//   bus   : slv side of conv1d_psum_accum_if (beat input, result output)
//   Optional feature macro: CONV1D_ACC_RELU_EN (handled in conv1d_round_sat)
module conv1d_psum_accum
    import conv1d_psum_accum_pkg::*;
#(
    parameter int ACC_LEN = ACC_LEN_DEF,
    parameter int SHIFT_W = SHIFT_W_DEF,
    parameter int ACC_W   = acc_width(ACC_LEN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    conv1d_psum_accum_if.slv      bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_RND  = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    localparam int CNT_W = $clog2(ACC_LEN + 1);

    logic [1:0]                    state;
    logic signed [ACC_W-1:0]       acc;
    logic        [CNT_W-1:0]       cnt;
    logic        [SHIFT_W-1:0]     shift_q;
    logic                          accept;
    logic signed [ACC_W-1:0]       psum_ext;
    logic signed [ACC_W-1:0]       bias_ext;
    logic signed [WIDTH_DATA-1:0]  rs_data;
    logic                          rs_ovf;

    assign bus.in_ready = (state == S_IDLE) || (state == S_ACC);
    assign accept       = bus.in_valid && bus.in_ready;
    assign psum_ext     = ACC_W'(bus.in_psum);
    assign bias_ext     = ACC_W'(bus.in_bias);

    conv1d_round_sat #(
        .ACC_W      (ACC_W),
        .SHIFT_W    (SHIFT_W),
        .WIDTH_DATA (WIDTH_DATA)
    ) u_round_sat (
        .acc   (acc),
        .shift (shift_q),
        .data  (rs_data),
        .ovf   (rs_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            acc           <= '0;
            cnt           <= '0;
            shift_q       <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_ovf   <= 1'b0;
        end else if (clr) begin
            // Abort wins over everything, including a beat offered this cycle.
            state         <= S_IDLE;
            acc           <= '0;
            cnt           <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        acc     <= bias_ext + psum_ext;
                        cnt     <= CNT_W'(1);
                        shift_q <= bus.cfg_shift;
                        state   <= (ACC_LEN == 1) ? S_RND : S_ACC;
                    end
                end
                S_ACC: begin
                    if (accept) begin
                        acc <= acc + psum_ext;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(ACC_LEN - 1)) begin
                            state <= S_RND;
                        end
                    end
                end
                S_RND: begin
                    bus.out_data  <= rs_data;
                    bus.out_ovf   <= rs_ovf;
                    bus.out_valid <= 1'b1;
                    state         <= S_OUT;
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv1d_psum_accum.sv
// tb/tb_conv1d_psum_accum.sv - self-checking bench for conv1d_psum_accum with a reference model
module tb_conv1d_psum_accum;
    import conv1d_psum_accum_pkg::*;

    localparam int ACC_LEN = 3;
    localparam int SW      = 5;
    localparam int PW      = 2 * WIDTH_DATA;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clr   = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    conv1d_psum_accum_if #(.WIDTH_DATA(WIDTH_DATA), .SHIFT_W(SW)) bus ();

    conv1d_psum_accum #(.ACC_LEN(ACC_LEN), .SHIFT_W(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: round half up by floor((acc + 2^(s-1)) / 2^s), optional ReLU, clamp.
    function automatic void model(input longint acc, input int sh,
                                  output longint d, output longint o);
        longint r;
        longint hi;
        longint lo;
        hi = (longint'(1) << (WIDTH_DATA - 1)) - 1;
        lo = -hi - 1;
        if (sh == 0) r = acc;
        else         r = (acc + (longint'(1) << (sh - 1))) >>> sh;
`ifdef CONV1D_ACC_RELU_EN
        if (r < 0) r = 0;
`endif
        o = 0;
        d = r;
        if (r > hi) begin d = hi; o = 1; end
        else if (r < lo) begin d = lo; o = 1; end
    endfunction

    task automatic push(input longint psum, input longint bias, input int sh, input bit gap);
        int n;
        if (gap) repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("push_timeout", 0, 1);
        bus.in_valid  = 1'b1;
        bus.in_psum   = PW'(psum);
        bus.in_bias   = PW'(bias);
        bus.cfg_shift = SW'(sh);
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
    endtask

    // Later beats carry junk bias/shift: only the first beat's values may be used.
    task automatic run_group(input longint bias, input longint p0, input longint p1,
                             input longint p2, input int sh, input bit gap);
        push(p0, bias, sh, gap);
        push(p1, longint'($urandom_range(0, 30000)), int'($urandom_range(0, 31)), gap);
        push(p2, longint'($urandom_range(0, 30000)), int'($urandom_range(0, 31)), gap);
        @(negedge clk);
        check("lat_rnd_valid", bus.out_valid, 0);
        @(negedge clk);
        check("lat_out_valid", bus.out_valid, 1);
        check("out_in_ready", bus.in_ready, 0);
    endtask

    task automatic take(input longint ed, input longint eo, input int hold, input bit pulse);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (pulse) begin
                bus.in_valid = ~bus.in_valid;
                bus.in_psum  = PW'(999);
            end
            check("hold_data", bus.out_data, ed);
            check("hold_in_ready", bus.in_ready, 0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("out_valid", bus.out_valid, 1);
        check("out_data", bus.out_data, ed);
        check("out_ovf", bus.out_ovf, eo);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("drain_valid", bus.out_valid, 0);
        check("drain_in_ready", bus.in_ready, 1);
    endtask

    initial begin
        longint p[3];
        longint bias;
        longint d;
        longint o;
        int     sh;
        logic signed [PW-1:0] t;

        bus.in_valid  = 1'b0;
        bus.in_psum   = '0;
        bus.in_bias   = '0;
        bus.cfg_shift = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_ovf", bus.out_ovf, 0);
        check("rst_in_ready2", bus.in_ready, 1);

        run_group(10, 100, 200, -50, 2, 0);
        take(65, 0, 0, 0);

        run_group(0, 1000, 1000, 1000, 0, 0);
        take(127, 1, 0, 0);

        run_group(0, -1000, -1000, -1000, 0, 0);
`ifdef CONV1D_ACC_RELU_EN
        take(0, 0, 0, 0);
`else
        take(-128, 1, 0, 0);
`endif

        run_group(0, 2, 2, 2, 2, 0);
        take(2, 0, 0, 0);
        run_group(0, -2, -2, -2, 2, 0);
`ifdef CONV1D_ACC_RELU_EN
        take(0, 0, 0, 0);
`else
        take(-1, 0, 0, 0);
`endif
        run_group(0, -1, -1, 0, 2, 0);
        take(0, 0, 0, 0);

        run_group(10, 100, 200, -50, 2, 0);
        take(65, 0, 5, 1);
        run_group(0, 1, 2, 3, 0, 0);
        take(6, 0, 0, 0);

        push(500, 700, 0, 0);
        push(500, 0, 0, 0);
        @(negedge clk);
        clr          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_psum  = PW'(100);
        @(posedge clk);
        #1;
        clr          = 1'b0;
        bus.in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("clr_in_ready", bus.in_ready, 1);
            check("clr_out_valid", bus.out_valid, 0);
        end
        run_group(0, 1, 2, 3, 0, 0);
        take(6, 0, 0, 0);

        run_group(0, 1000, 1000, 1000, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_out_data", bus.out_data, 0);
        check("arst_out_ovf", bus.out_ovf, 0);
        check("arst_in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        run_group(0, 1, 2, 3, 0, 0);
        take(6, 0, 0, 0);

        for (int g = 0; g < 40; g++) begin
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    t = PW'($urandom);
                    p[k] = longint'(t);
                end else begin
                    p[k] = longint'($urandom_range(0, 4000)) - 2000;
                end
            end
            t    = PW'($urandom);
            bias = ($urandom_range(0, 1) == 0) ? longint'(t) : longint'($urandom_range(0, 200)) - 100;
            sh   = int'($urandom_range(0, 31));
            model(bias + p[0] + p[1] + p[2], sh, d, o);
            run_group(bias, p[0], p[1], p[2], sh, 1'b1);
            take(d, o, int'($urandom_range(0, 3)), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end
endmodule
